// File: rtl/uart_baud_gen.sv
// UART baud generator: oversampled rx tick, bit-rate tx tick and 50% duty tx clock.
// The divisor comes from an elaboration-time table or a programmed register and only
// changes while idle or on a bit boundary.
module uart_baud_gen #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned DEF_SEL    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       baud_sel,
  input  logic             use_div,
  input  logic             div_wr,
  input  logic [DIV_W-1:0] div_in,
  output logic             rx_tick,
  output logic             tx_tick,
  output logic             tx_clk,
  output logic [DIV_W-1:0] active_div,
  output logic             cfg_pending,
  output logic             cfg_err
);

  localparam int unsigned SubW = $clog2(OVERSAMPLE);

  function automatic int unsigned calc_div(input int unsigned baud);
    longint unsigned den;
    den = longint'(OVERSAMPLE) * longint'(baud);
    return 32'((longint'(CLK_HZ) + den / 2) / den);
  endfunction

  localparam int unsigned TblDiv [8] = '{
    calc_div(4800),  calc_div(9600),  calc_div(14400),  calc_div(19200),
    calc_div(38400), calc_div(57600), calc_div(115200), calc_div(9600)
  };

  localparam logic [DIV_W-1:0] DefDiv = DIV_W'(TblDiv[DEF_SEL]);

  for (genvar i = 0; i < 8; i++) begin : g_tbl_chk
    if (TblDiv[i] < 2 || longint'(TblDiv[i]) > ((longint'(1) << DIV_W) - 1)) begin : g_bad
      $error("uart_baud_gen: table divisor out of range");
    end
  end

  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_os_bad
    $error("uart_baud_gen: OVERSAMPLE must be even and at least 4");
  end

  logic [DIV_W-1:0] prog_div_q;
  logic [DIV_W-1:0] active_div_q;
  logic [DIV_W-1:0] cnt_q;
  logic [SubW-1:0]  sub_q;
  logic             rx_tick_q, tx_tick_q, tx_clk_q, cfg_err_q;

  logic [DIV_W-1:0] target;
  logic             cnt_wrap, sub_wrap, sub_half;

  always_comb begin
    target   = use_div ? prog_div_q : DIV_W'(TblDiv[baud_sel]);
    cnt_wrap = (cnt_q == active_div_q - DIV_W'(1));
    sub_wrap = (sub_q == SubW'(OVERSAMPLE - 1));
    sub_half = (sub_q == SubW'(OVERSAMPLE / 2 - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prog_div_q   <= DefDiv;
      active_div_q <= DefDiv;
      cnt_q        <= '0;
      sub_q        <= '0;
      rx_tick_q    <= 1'b0;
      tx_tick_q    <= 1'b0;
      tx_clk_q     <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      // Programming is independent of en; invalid divisors are dropped and flagged.
      if (div_wr) begin
        if (div_in >= DIV_W'(2)) begin
          prog_div_q <= div_in;
          cfg_err_q  <= 1'b0;
        end else begin
          cfg_err_q  <= 1'b1;
        end
      end

      if (!en) begin
        cnt_q        <= '0;
        sub_q        <= '0;
        rx_tick_q    <= 1'b0;
        tx_tick_q    <= 1'b0;
        tx_clk_q     <= 1'b0;
        active_div_q <= target;
      end else begin
        rx_tick_q <= cnt_wrap;
        tx_tick_q <= cnt_wrap && sub_wrap;
        if (cnt_wrap) begin
          cnt_q <= '0;
          sub_q <= sub_wrap ? '0 : sub_q + SubW'(1);
          if (sub_half || sub_wrap) begin
            tx_clk_q <= ~tx_clk_q;
          end
          // Bit boundary: the only place a running divisor may change.
          if (sub_wrap) begin
            active_div_q <= target;
          end
        end else begin
          cnt_q <= cnt_q + DIV_W'(1);
        end
      end
    end
  end

  assign rx_tick     = rx_tick_q;
  assign tx_tick     = tx_tick_q;
  assign tx_clk      = tx_clk_q;
  assign active_div  = active_div_q;
  assign cfg_err     = cfg_err_q;
  assign cfg_pending = (target != active_div_q);

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen with hand-computed periods and table values.
module tb_uart_baud_gen;

  logic        clk;
  logic        rst;
  logic        en;
  logic [2:0]  baud_sel;
  logic        use_div;
  logic        div_wr;
  logic [15:0] div_in;
  logic        rx_tick, tx_tick, tx_clk, cfg_pending, cfg_err;
  logic [15:0] active_div;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int Limit = 20000;
  int exp_tbl [8] = '{651, 326, 217, 163, 81, 54, 27, 326};

  uart_baud_gen #(
    .CLK_HZ(50000000),
    .OVERSAMPLE(16),
    .DIV_W(16),
    .DEF_SEL(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .baud_sel(baud_sel),
    .use_div(use_div),
    .div_wr(div_wr),
    .div_in(div_in),
    .rx_tick(rx_tick),
    .tx_tick(tx_tick),
    .tx_clk(tx_clk),
    .active_div(active_div),
    .cfg_pending(cfg_pending),
    .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit sig(input int which);
    case (which)
      0:       return rx_tick;
      1:       return tx_tick;
      2:       return tx_clk;
      default: return !tx_clk;
    endcase
  endfunction

  // Negedges until the selected condition is seen (bounded).
  task automatic cycles_to(input int which, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sig(which) && n < Limit);
  endtask

  task automatic write_div(input logic [15:0] val);
    div_wr = 1'b1;
    div_in = val;
    @(negedge clk);
    div_wr = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; en = 1'b0; baud_sel = 3'd1; use_div = 1'b0; div_wr = 1'b0; div_in = '0;
    repeat (3) @(negedge clk);
    check("rst_rx", rx_tick, 0);
    check("rst_tx", tx_tick, 0);
    check("rst_txclk", tx_clk, 0);
    check("rst_active", active_div, 326);
    check("rst_err", cfg_err, 0);
    check("rst_pend", cfg_pending, 0);

    // Table rate 9600: D=326
    rst = 1'b0; en = 1'b1;
    cycles_to(0, n); check("t1_first_rx", n, 326);
    @(negedge clk);  check("t1_rx_width", rx_tick, 0);
    cycles_to(1, n);
    check("t1_tx_txclk_low", tx_clk, 0);
    check("t1_tx_with_rx", rx_tick, 1);
    cycles_to(1, n); check("t1_tx_period", n, 5216);
    cycles_to(2, n); check("t1_txclk_low_len", n, 2608);
    cycles_to(3, n); check("t1_txclk_high_len", n, 2608);

    // Programmed D=4
    en = 1'b0; use_div = 1'b1;
    write_div(16'd4);
    @(negedge clk);
    check("t2_active", active_div, 4);
    check("t2_pend", cfg_pending, 0);
    en = 1'b1;
    cycles_to(0, n); check("t2_first_rx", n, 4);
    en = 1'b0;
    @(negedge clk);
    check("t2_off_rx", rx_tick, 0);
    en = 1'b1;
    cycles_to(1, n); check("t2_first_tx", n, 64);
    cycles_to(2, n); check("t2_txclk_low_len", n, 32);
    cycles_to(3, n); check("t2_txclk_high_len", n, 32);
    check("t2_tx_at_fall", tx_tick, 1);

    // Mid-bit write of 6 takes effect only at the next bit boundary
    repeat (10) @(negedge clk);
    write_div(16'd6);
    check("t3_pend_mid", cfg_pending, 1);
    check("t3_active_mid", active_div, 4);
    cycles_to(1, n); check("t3_old_bit_len", n + 11, 64);
    check("t3_active_new", active_div, 6);
    check("t3_pend_clear", cfg_pending, 0);
    cycles_to(0, n); check("t3_rx_period", n, 6);
    cycles_to(1, n); check("t3_new_bit_len", n + 6, 96);

    // Rejected and accepted writes
    write_div(16'd1);
    check("t4_err_set", cfg_err, 1);
    check("t4_prog_kept", cfg_pending, 0);
    write_div(16'd5);
    check("t4_err_clr", cfg_err, 0);
    check("t4_pend_new", cfg_pending, 1);
    write_div(16'd0);
    check("t4_err_set2", cfg_err, 1);

    // Reset mid-bit with a simultaneous write
    repeat (7) @(negedge clk);
    rst = 1'b1; div_wr = 1'b1; div_in = 16'd9;
    @(negedge clk);
    rst = 1'b0; div_wr = 1'b0; en = 1'b0;
    check("t5_rx", rx_tick, 0);
    check("t5_tx", tx_tick, 0);
    check("t5_txclk", tx_clk, 0);
    check("t5_active", active_div, 326);
    check("t5_err", cfg_err, 0);
    check("t5_pend", cfg_pending, 0);
    repeat (2) @(negedge clk);
    check("t5_prog_def", active_div, 326);

    // Minimum divisor D=2
    write_div(16'd2);
    @(negedge clk);
    en = 1'b1;
    cycles_to(0, n); check("t6_first_rx", n, 2);
    @(negedge clk);  check("t6_rx_low", rx_tick, 0);
    @(negedge clk);  check("t6_rx_high", rx_tick, 1);
    en = 1'b0;
    @(negedge clk);  check("t6_off_rx", rx_tick, 0);

    // Table sweep while idle
    use_div = 1'b0; baud_sel = 3'd0;
    #1 check("t7_pend", cfg_pending, 1);
    for (int i = 0; i < 8; i++) begin
      baud_sel = 3'(i);
      @(negedge clk);
      check($sformatf("t7_tbl%0d", i), active_div, exp_tbl[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
